// File: rtl/rob_retire_if.sv
// rob_retire_if: dispatch, completion, retire and flush-rollback signals
// between the rename/dispatch pipeline and rob_retire_ctrl.
interface rob_retire_if #(
  parameter int IDX_W = 6
);
  logic             alloc_valid;
  logic             alloc_ready;
  logic             alloc_has_dest;
  logic [5:0]       alloc_dest_preg;
  logic [5:0]       alloc_old_preg;
  logic [IDX_W-1:0] alloc_idx;

  logic [3:0]         cmpl_valid;
  logic [4*IDX_W-1:0] cmpl_idx;

  logic flush;

  logic       ret0_valid;
  logic       ret0_has_dest;
  logic [5:0] ret0_old_preg;
  logic [5:0] ret0_dest_preg;
  logic       ret1_valid;
  logic       ret1_has_dest;
  logic [5:0] ret1_old_preg;
  logic [5:0] ret1_dest_preg;

  logic           free_valid;
  logic [5:0]     free_preg;
  logic [IDX_W:0] count;
  logic           flush_busy;

  // ROB side
  modport slave (
    input  alloc_valid, alloc_has_dest, alloc_dest_preg, alloc_old_preg,
           cmpl_valid, cmpl_idx, flush,
    output alloc_ready, alloc_idx,
           ret0_valid, ret0_has_dest, ret0_old_preg, ret0_dest_preg,
           ret1_valid, ret1_has_dest, ret1_old_preg, ret1_dest_preg,
           free_valid, free_preg, count, flush_busy
  );

  // dispatch / pipeline side
  modport master (
    output alloc_valid, alloc_has_dest, alloc_dest_preg, alloc_old_preg,
           cmpl_valid, cmpl_idx, flush,
    input  alloc_ready, alloc_idx,
           ret0_valid, ret0_has_dest, ret0_old_preg, ret0_dest_preg,
           ret1_valid, ret1_has_dest, ret1_old_preg, ret1_dest_preg,
           free_valid, free_preg, count, flush_busy
  );
endinterface

// File: rtl/rob_retire_ctrl.sv
// rob_retire_ctrl: reorder-buffer allocation, completion tracking, in-order
// retirement and tail-first flush rollback.
// Optional macro ROB_DUAL_RETIRE_EN enables a second retire slot; without it
// at most one entry retires per cycle and ret1_* are tied low.
//
// state | meaning
// RUN   | accept allocs, record completions, retire from head
// FLUSH | walk tail back one entry per cycle, releasing dest regs
module rob_retire_ctrl #(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input logic         clk,
  input logic         rstn,
  rob_retire_if.slave bus
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

  state_t           state;
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W-1:0] tail_m1;
  logic [IDX_W:0]   count;

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_cmpl;
  logic [DEPTH-1:0] ent_has_dest;
  logic [5:0]       ent_dest [DEPTH];
  logic [5:0]       ent_old  [DEPTH];

  logic run_ok;
  logic accept;
  logic fire0;
  logic fire1;

  logic       r0_valid;
  logic       r0_has_dest;
  logic [5:0] r0_dest;
  logic [5:0] r0_old;
  logic       free_valid_q;
  logic [5:0] free_preg_q;
  logic       flush_busy_q;

`ifdef ROB_DUAL_RETIRE_EN
  logic [IDX_W-1:0] head_p1;
  logic             r1_valid;
  logic             r1_has_dest;
  logic [5:0]       r1_dest;
  logic [5:0]       r1_old;

  assign head_p1 = head + IDX_W'(1);
`endif

  assign tail_m1 = tail - IDX_W'(1);

  // Full check uses the registered count only, so a same-cycle retire never
  // opens a slot for a same-cycle alloc.
  assign bus.alloc_ready = rstn && (state == RUN) && (count < FULL_CNT) && !bus.flush;
  assign bus.alloc_idx   = tail;
  assign bus.count       = count;
  assign bus.flush_busy  = flush_busy_q;
  assign bus.free_valid  = free_valid_q;
  assign bus.free_preg   = free_preg_q;

  assign bus.ret0_valid     = r0_valid;
  assign bus.ret0_has_dest  = r0_has_dest;
  assign bus.ret0_dest_preg = r0_dest;
  assign bus.ret0_old_preg  = r0_old;

`ifdef ROB_DUAL_RETIRE_EN
  assign bus.ret1_valid     = r1_valid;
  assign bus.ret1_has_dest  = r1_has_dest;
  assign bus.ret1_dest_preg = r1_dest;
  assign bus.ret1_old_preg  = r1_old;
`else
  assign bus.ret1_valid     = 1'b0;
  assign bus.ret1_has_dest  = 1'b0;
  assign bus.ret1_dest_preg = 6'd0;
  assign bus.ret1_old_preg  = 6'd0;
`endif

  // Retire and alloc decisions for this cycle, from pre-edge entry state.
  always_comb begin
    run_ok = (state == RUN) && !bus.flush;
    accept = bus.alloc_valid && bus.alloc_ready;
    fire0  = run_ok && ent_valid[head] && ent_cmpl[head];
`ifdef ROB_DUAL_RETIRE_EN
    fire1  = fire0 && ent_valid[head_p1] && ent_cmpl[head_p1];
`else
    fire1  = 1'b0;
`endif
  end

  // FSM, entry array, pointers and registered retire/free outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= RUN;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      ent_valid    <= '0;
      ent_cmpl     <= '0;
      r0_valid     <= 1'b0;
      r0_has_dest  <= 1'b0;
      r0_dest      <= 6'd0;
      r0_old       <= 6'd0;
      free_valid_q <= 1'b0;
      free_preg_q  <= 6'd0;
      flush_busy_q <= 1'b0;
`ifdef ROB_DUAL_RETIRE_EN
      r1_valid     <= 1'b0;
      r1_has_dest  <= 1'b0;
      r1_dest      <= 6'd0;
      r1_old       <= 6'd0;
`endif
    end else begin
      r0_valid     <= 1'b0;
      r0_has_dest  <= 1'b0;
      r0_dest      <= 6'd0;
      r0_old       <= 6'd0;
      free_valid_q <= 1'b0;
      free_preg_q  <= 6'd0;
`ifdef ROB_DUAL_RETIRE_EN
      r1_valid     <= 1'b0;
      r1_has_dest  <= 1'b0;
      r1_dest      <= 6'd0;
      r1_old       <= 6'd0;
`endif
      case (state)
        RUN: begin
          if (bus.flush) begin
            state        <= FLUSH;
            flush_busy_q <= 1'b1;
          end else begin
            // Completions only mark entries that are currently live.
            for (int k = 0; k < 4; k++) begin
              if (bus.cmpl_valid[k] && ent_valid[bus.cmpl_idx[k*IDX_W +: IDX_W]])
                ent_cmpl[bus.cmpl_idx[k*IDX_W +: IDX_W]] <= 1'b1;
            end
            if (fire0) begin
              ent_valid[head] <= 1'b0;
              r0_valid        <= 1'b1;
              r0_has_dest     <= ent_has_dest[head];
              r0_dest         <= ent_dest[head];
              r0_old          <= ent_old[head];
            end
`ifdef ROB_DUAL_RETIRE_EN
            if (fire1) begin
              ent_valid[head_p1] <= 1'b0;
              r1_valid           <= 1'b1;
              r1_has_dest        <= ent_has_dest[head_p1];
              r1_dest            <= ent_dest[head_p1];
              r1_old             <= ent_old[head_p1];
            end
`endif
            // Alloc last: its complete=0 must win over any stale strobe.
            if (accept) begin
              ent_valid[tail]    <= 1'b1;
              ent_cmpl[tail]     <= 1'b0;
              ent_has_dest[tail] <= bus.alloc_has_dest;
              ent_dest[tail]     <= bus.alloc_dest_preg;
              ent_old[tail]      <= bus.alloc_old_preg;
              tail               <= tail + IDX_W'(1);
            end
            head  <= head + IDX_W'(fire0) + IDX_W'(fire1);
            count <= count + (IDX_W+1)'(accept) - (IDX_W+1)'(fire0) - (IDX_W+1)'(fire1);
          end
        end
        FLUSH: begin
          if (count == '0) begin
            state        <= RUN;
            flush_busy_q <= 1'b0;
          end else begin
            tail               <= tail_m1;
            ent_valid[tail_m1] <= 1'b0;
            count              <= count - (IDX_W+1)'(1);
            if (ent_has_dest[tail_m1]) begin
              free_valid_q <= 1'b1;
              free_preg_q  <= ent_dest[tail_m1];
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: doc/rob_retire_ctrl.md
ROB_RETIRE_CTRL -- requirements
Module: rob_retire_ctrl

Interface
REQ-001 Parameter DEPTH, 64, ROB entries; SHALL be a power of two.
REQ-002 Parameter IDX_W, 6, log2(DEPTH); entry index width.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rstn  in  1  reset, synchronous, active-low.
REQ-005 alloc_valid  in  1  dispatch requests one entry.
REQ-006 alloc_ready  out  1  entry can be accepted this cycle.
REQ-007 alloc_has_dest  in  1  instruction writes a physical register.
REQ-008 alloc_dest_preg  in  6  new physical destination.
REQ-009 alloc_old_preg  in  6  previous mapping of the architectural destination.
REQ-010 alloc_idx  out  IDX_W  index assigned to the accepted entry; equals tail.
REQ-011 cmpl_valid  in  4  per-FU completion strobe.
REQ-012 cmpl_idx  in  4*IDX_W  per-FU completing entry index; FU k uses bits [k*IDX_W +: IDX_W].
REQ-013 flush  in  1  discard all unretired entries.
REQ-014 ret0_valid, ret1_valid  out  1 each  retire slot 0/1 fired.
REQ-015 ret0_has_dest, ret1_has_dest  out  1 each  retired entry had a destination.
REQ-016 ret0_old_preg, ret1_old_preg  out  6 each  register to return to the free list.
REQ-017 ret0_dest_preg, ret1_dest_preg  out  6 each  register to commit to the architectural map.
REQ-018 free_valid  out  1  flush rollback releases free_preg.
REQ-019 free_preg  out  6  rolled-back destination register.
REQ-020 count  out  IDX_W+1  occupied entries, 0..DEPTH.
REQ-021 flush_busy  out  1  high while in FLUSH.

Function
REQ-022 Per-entry state: valid, complete, has_dest, dest_preg, old_preg; head and tail pointers IDX_W bits, wrapping DEPTH-1 to 0.
REQ-023 FSM states RUN and FLUSH; alloc_ready = (state==RUN) & (count<DEPTH) & ~flush, combinational.
REQ-024 Alloc handshake: on alloc_valid & alloc_ready, entry[tail] written valid=1, complete=0, tail+1.
REQ-025 Full: count==DEPTH SHALL deassert alloc_ready even if retirement frees entries the same cycle (no bypass).
REQ-026 Completion: each cmpl_valid[k] whose entry is valid sets complete at the edge; strobes to invalid entries ignored; duplicate indices allowed; new complete bits visible to retire the next cycle.
REQ-027 Retire in RUN without flush: slot 0 fires if entry[head] valid & complete; slot 1 fires only if slot 0 fires and entry[head+1] valid & complete; fired entries invalidated, head advances by fired count.
REQ-028 ret* outputs registered: asserted the cycle after the retire decision edge, for exactly one cycle per retired entry, slot 0 older than slot 1.
REQ-029 count next = count + accepted alloc - retired entries.
REQ-030 flush sampled high in RUN: no alloc, retire or completion that edge; state -> FLUSH.
REQ-031 FLUSH, per cycle: if count==0 -> RUN; else tail-1, entry[tail-1] invalidated, count-1, and if it had has_dest, free_valid=1 and free_preg=its dest_preg next cycle.
REQ-032 In FLUSH, flush input and completions SHALL be ignored; alloc_ready=0; no retire.
REQ-033 Empty ROB: flush SHALL spend one FLUSH cycle, then return to RUN with no free_valid.

Reset
REQ-034 rstn low at an edge: state RUN, head=tail=0, all valid/complete=0, count=0, all ret*/free_* outputs 0, flush_busy=0; alloc_ready low while rstn low.
REQ-035 Reset mid-FLUSH or mid-retire SHALL abort it with no further free_valid or ret*_valid pulses.

Configuration
REQ-036 Macro ROB_DUAL_RETIRE_EN defined: two retire slots per REQ-027.
REQ-037 Macro ROB_DUAL_RETIRE_EN undefined: slot 1 never fires; ret1_* outputs tied 0; retire at most one entry per cycle.

Verification
REQ-038 Reset, alloc 64 entries -> alloc_idx 0..63, count=64, alloc_ready=0 on the 65th request.
REQ-039 Alloc idx 0,1,2; complete 2 then 0 -> ret0_valid for idx0 only; complete 1 -> idx1 and idx2 retire same cycle (slot0, slot1) with dual retire, consecutive cycles without it.
REQ-040 Full ROB, head complete, alloc_valid held -> alloc refused that cycle, accepted next cycle at idx 0 (wrap), count stays 64.
REQ-041 Entries 5 allocated (has_dest 1,0,1,1,0; dest 10..14), flush -> free_preg 13, 12, 10 in order, flush_busy high 6 cycles, count 0, alloc_ready high after.
REQ-042 Completion strobes to invalid idx 40 and duplicate idx 3 on two FUs -> no state change for 40, single retirement of 3.
REQ-043 rstn low during FLUSH with 10 entries -> next cycle count=0, free_valid=0, state RUN.
